// File: rtl/instr_mem_loader.sv
// -----------------------------------------------------------------------------
// instr_mem_loader
//
// Boot-time writer for the instruction memory. A host byte link (UART or debug
// port) streams an image over a valid/ready handshake:
//
//   bytes 0..3      : word_count N, little-endian
//   bytes 4..4N+3   : N instruction words, each little-endian
//
// Each completed data word is written to the instruction memory write port
// with a one-cycle we_o pulse, at byte address BASE_ADDR + 4*word_idx. The
// core (PC and fetch path) is held in reset until all N words are written.
//
// Parameters:
//   ADDR_WIDTH  word-address width of the instruction memory (depth 2**ADDR_WIDTH)
//   BASE_ADDR   byte address of the first word written (word aligned)
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous active-high reset
//   start_i       restart load (one-cycle pulse); priority over everything else
//   byte_i        incoming stream byte
//   byte_valid_i  byte_i valid
//   byte_ready_o  loader can accept a byte (LEN and DATA only)
//   we_o          instruction memory write enable, one-cycle pulse per word
//   waddr_o       byte address of the write
//   wdata_o       write data word
//   core_rst_o    reset to PC/core, active-high; released once the image is in
//   busy_o        load in progress (LEN or DATA)
//   done_o        image loaded
//   err_o         announced length exceeds the memory depth
//
// All outputs are registered.
// -----------------------------------------------------------------------------
module instr_mem_loader #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [7:0]  byte_i,
    input  logic        byte_valid_i,
    output logic        byte_ready_o,
    output logic        we_o,
    output logic [31:0] waddr_o,
    output logic [31:0] wdata_o,
    output logic        core_rst_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o
);

    // -------------------------------------------------------------------------
    // Types and constants
    // -------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_LEN  = 2'd0,
        S_DATA = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    // Memory depth in words. One extra bit so that a 32-bit word count can be
    // compared against 2**32 when ADDR_WIDTH is 32.
    localparam logic [32:0] DEPTH = 33'(1) << ADDR_WIDTH;

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    state_t      state_q,    state_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;   // byte lane of the next accepted byte
    logic [23:0] shift_q,    shift_d;      // lanes 0..2 of the word being built
    logic [31:0] len_q,      len_d;        // announced word count N
    logic [31:0] word_idx_q, word_idx_d;   // index of the next word to write

    // Registered outputs
    logic        byte_ready_q, byte_ready_d;
    logic        we_q,         we_d;
    logic [31:0] waddr_q,      waddr_d;
    logic [31:0] wdata_q,      wdata_d;
    logic        core_rst_q,   core_rst_d;
    logic        busy_q,       busy_d;
    logic        done_q,       done_d;
    logic        err_q,        err_d;

    // -------------------------------------------------------------------------
    // Handshake decode
    // -------------------------------------------------------------------------
    logic        accept;       // byte transferred on this edge
    logic        word_last;    // accepted byte completes a 32-bit word
    logic [31:0] assembled;    // the completed word when word_last is set
    logic        image_last;   // word being completed is word N-1

    // byte_ready_q is only ever high in LEN and DATA, so acceptance needs no
    // additional state qualification.
    assign accept     = byte_valid_i & byte_ready_q;
    assign word_last  = accept & (byte_cnt_q == 2'd3);
    assign assembled  = {byte_i, shift_q};
    assign image_last = (word_idx_q == (len_q - 32'd1));

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_LEN;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every signal assigned in an always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;

        if (start_i) begin
            state_d = S_LEN;
        end else begin
            unique case (state_q)
                S_LEN: begin
                    if (word_last) begin
                        if (assembled == 32'd0) begin
                            state_d = S_DONE;
                        end else if ({1'b0, assembled} > DEPTH) begin
                            state_d = S_ERR;
                        end else begin
                            state_d = S_DATA;
                        end
                    end
                end
                // Leaving DATA on the completing edge puts DONE in the same
                // cycle as the final we_o pulse.
                S_DATA: begin
                    if (word_last && image_last) begin
                        state_d = S_DONE;
                    end
                end
                S_DONE:  state_d = S_DONE;
                S_ERR:   state_d = S_ERR;
                default: state_d = S_LEN;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // FSM: output logic (next values of the registered outputs)
    // -------------------------------------------------------------------------
    always_comb begin
        // Ready follows the destination state, and is dropped for the cycle
        // after a restart so a byte presented with start_i is not re-taken.
        byte_ready_d = !start_i && ((state_d == S_LEN) || (state_d == S_DATA));
        busy_d       = (state_d == S_LEN) || (state_d == S_DATA);
        err_d        = (state_d == S_ERR);

        // done_o and the core reset release lag entry into DONE by one cycle,
        // so the core leaves reset only after the last write has been issued.
        done_d       = !start_i && (state_q == S_DONE);
        core_rst_d   = !done_d;

        // A word completed in the same cycle as start_i is discarded.
        we_d         = !start_i && (state_q == S_DATA) && word_last;

        // Address and data hold their last written values between writes.
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;
        if (we_d) begin
            waddr_d = BASE_ADDR + (word_idx_q << 2);
            wdata_d = assembled;
        end
    end

    // -------------------------------------------------------------------------
    // Datapath: byte lane counter, shift register, length and word index
    // -------------------------------------------------------------------------
    always_comb begin
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        len_d      = len_q;
        word_idx_d = word_idx_q;

        if (start_i) begin
            // Restart drops any partially assembled word, including a byte
            // presented in this very cycle.
            byte_cnt_d = 2'd0;
            shift_d    = 24'd0;
            len_d      = 32'd0;
            word_idx_d = 32'd0;
        end else if (accept) begin
            byte_cnt_d = byte_cnt_q + 2'd1;   // wraps 3 -> 0

            // Little-endian: byte k lands in bits [8k+7:8k]. Lane 3 is never
            // stored; it is taken straight from byte_i when the word completes.
            unique case (byte_cnt_q)
                2'd0:    shift_d[7:0]   = byte_i;
                2'd1:    shift_d[15:8]  = byte_i;
                2'd2:    shift_d[23:16] = byte_i;
                default: shift_d        = shift_q;
            endcase

            if (word_last) begin
                if (state_q == S_LEN) begin
                    len_d      = assembled;
                    word_idx_d = 32'd0;
                end else if (state_q == S_DATA) begin
                    word_idx_d = word_idx_q + 32'd1;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Datapath and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt_q   <= 2'd0;
            shift_q      <= 24'd0;
            len_q        <= 32'd0;
            word_idx_q   <= 32'd0;

            byte_ready_q <= 1'b0;
            we_q         <= 1'b0;
            waddr_q      <= BASE_ADDR;
            wdata_q      <= 32'd0;
            core_rst_q   <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            byte_cnt_q   <= byte_cnt_d;
            shift_q      <= shift_d;
            len_q        <= len_d;
            word_idx_q   <= word_idx_d;

            byte_ready_q <= byte_ready_d;
            we_q         <= we_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            core_rst_q   <= core_rst_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    // -------------------------------------------------------------------------
    // Output ports
    // -------------------------------------------------------------------------
    assign byte_ready_o = byte_ready_q;
    assign we_o         = we_q;
    assign waddr_o      = waddr_q;
    assign wdata_o      = wdata_q;
    assign core_rst_o   = core_rst_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// -----------------------------------------------------------------------------
// tb_instr_mem_loader
//
// Two loaders share one stimulus driver; only the selected one sees valid and
// start. Instance A: ADDR_WIDTH=10, BASE_ADDR=0. Instance B: ADDR_WIDTH=4,
// BASE_ADDR=0x100. Expected writes are queued when the image is sent and
// popped by a per-instance monitor whenever we_o is seen.
// -----------------------------------------------------------------------------
module tb_instr_mem_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start_r;
    logic        valid_r;
    logic [7:0]  byte_r;
    int unsigned sel;

    // Instance A signals
    logic        start_a, valid_a;
    logic        ready_a, we_a, core_rst_a, busy_a, done_a, err_a;
    logic [31:0] waddr_a, wdata_a;
    // Instance B signals
    logic        start_b, valid_b;
    logic        ready_b, we_b, core_rst_b, busy_b, done_b, err_b;
    logic [31:0] waddr_b, wdata_b;

    assign start_a = (sel == 0) ? start_r : 1'b0;
    assign valid_a = (sel == 0) ? valid_r : 1'b0;
    assign start_b = (sel == 1) ? start_r : 1'b0;
    assign valid_b = (sel == 1) ? valid_r : 1'b0;

    instr_mem_loader #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0000_0000)) u_a (
        .clk(clk), .rst(rst), .start_i(start_a), .byte_i(byte_r),
        .byte_valid_i(valid_a), .byte_ready_o(ready_a), .we_o(we_a),
        .waddr_o(waddr_a), .wdata_o(wdata_a), .core_rst_o(core_rst_a),
        .busy_o(busy_a), .done_o(done_a), .err_o(err_a)
    );

    instr_mem_loader #(.ADDR_WIDTH(4), .BASE_ADDR(32'h0000_0100)) u_b (
        .clk(clk), .rst(rst), .start_i(start_b), .byte_i(byte_r),
        .byte_valid_i(valid_b), .byte_ready_o(ready_b), .we_o(we_b),
        .waddr_o(waddr_b), .wdata_o(wdata_b), .core_rst_o(core_rst_b),
        .busy_o(busy_b), .done_o(done_b), .err_o(err_b)
    );

    // Views of the selected instance
    logic rdy, done_s, err_s, core_rst_s, busy_s, we_s;
    always_comb begin
        rdy        = (sel == 0) ? ready_a    : ready_b;
        done_s     = (sel == 0) ? done_a     : done_b;
        err_s      = (sel == 0) ? err_a      : err_b;
        core_rst_s = (sel == 0) ? core_rst_a : core_rst_b;
        busy_s     = (sel == 0) ? busy_a     : busy_b;
        we_s       = (sel == 0) ? we_a       : we_b;
    end

    // -------------------------------------------------------------------------
    // Checking
    // -------------------------------------------------------------------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t q_a[$];
    wr_t q_b[$];

    always @(negedge clk) begin
        if (!rst && we_a === 1'b1) begin
            check("a_write_expected", 32'(q_a.size() != 0), 32'd1);
            if (q_a.size() != 0) begin
                wr_t e;
                e = q_a.pop_front();
                check("a_waddr", waddr_a, e.addr);
                check("a_wdata", wdata_a, e.data);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && we_b === 1'b1) begin
            check("b_write_expected", 32'(q_b.size() != 0), 32'd1);
            if (q_b.size() != 0) begin
                wr_t e;
                e = q_b.pop_front();
                check("b_waddr", waddr_b, e.addr);
                check("b_wdata", wdata_b, e.data);
            end
        end
    end

    function automatic logic [31:0] base_of(input int unsigned s);
        return (s == 0) ? 32'h0000_0000 : 32'h0000_0100;
    endfunction

    task automatic expect_write(input logic [31:0] addr, input logic [31:0] data);
        wr_t e;
        e.addr = addr;
        e.data = data;
        if (sel == 0) q_a.push_back(e);
        else          q_b.push_back(e);
    endtask

    function automatic int pending();
        return (sel == 0) ? q_a.size() : q_b.size();
    endfunction

    // -------------------------------------------------------------------------
    // Stimulus tasks (entered and left on a falling edge)
    // -------------------------------------------------------------------------
    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited;
        repeat (gap) @(negedge clk);
        valid_r = 1'b1;
        byte_r  = b;
        waited  = 0;
        while (!rdy && waited < 64) begin
            @(negedge clk);
            waited++;
        end
        check("byte_accepted", 32'(rdy), 32'd1);
        @(negedge clk);
        valid_r = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit rnd);
        for (int k = 0; k < 4; k++) begin
            send_byte(w[8*k +: 8], rnd ? int'($urandom_range(0, 5)) : 0);
        end
    endtask

    task automatic pulse_start();
        start_r = 1'b1;
        @(negedge clk);
        start_r = 1'b0;
    endtask

    // -------------------------------------------------------------------------
    // Vector table
    // -------------------------------------------------------------------------
    typedef struct packed {
        logic [31:0]       sel;
        logic [31:0]       n;
        logic [2:0][31:0]  w;       // w[0] sent first
        logic [31:0]       nsend;
        logic              rnd;
        logic              exp_done;
        logic              exp_err;
    } vec_t;

    localparam int NV = 6;
    vec_t vecs [NV];

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic exp_busy;
        logic [31:0] w0, w1;

        vecs[0] = '{sel: 0, n: 32'd2,  w: {32'h0, 32'h0020_0593, 32'h0010_0513}, nsend: 2, rnd: 0, exp_done: 1, exp_err: 0};
        vecs[1] = '{sel: 0, n: 32'd0,  w: {32'h0, 32'h0, 32'h0},                  nsend: 0, rnd: 0, exp_done: 1, exp_err: 0};
        vecs[2] = '{sel: 1, n: 32'd17, w: {32'h0, 32'h0, 32'h0},                  nsend: 0, rnd: 0, exp_done: 0, exp_err: 1};
        vecs[3] = '{sel: 1, n: 32'd16, w: {32'h0, 32'h0, 32'h0},                  nsend: 0, rnd: 0, exp_done: 0, exp_err: 0};
        vecs[4] = '{sel: 1, n: 32'd1,  w: {32'h0, 32'h0, 32'hDEAD_BEEF},          nsend: 1, rnd: 1, exp_done: 1, exp_err: 0};
        vecs[5] = '{sel: 0, n: 32'd3,  w: {32'h89AB_CDEF, 32'h0123_4567, 32'hA5A5_5A5A}, nsend: 3, rnd: 0, exp_done: 1, exp_err: 0};

        sel     = 0;
        rst     = 1'b1;
        start_r = 1'b0;
        valid_r = 1'b0;
        byte_r  = 8'h00;

        // ---- reset values ----
        repeat (2) @(negedge clk);
        check("rst_ready",    32'(ready_a),    32'd0);
        check("rst_we",       32'(we_a),       32'd0);
        check("rst_waddr_a",  waddr_a,         32'h0000_0000);
        check("rst_waddr_b",  waddr_b,         32'h0000_0100);
        check("rst_wdata",    wdata_a,         32'h0);
        check("rst_core_rst", 32'(core_rst_a), 32'd1);
        check("rst_busy",     32'(busy_a),     32'd0);
        check("rst_done",     32'(done_a),     32'd0);
        check("rst_err",      32'(err_a),      32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready_a", 32'(ready_a), 32'd1);
        check("post_rst_ready_b", 32'(ready_b), 32'd1);
        check("post_rst_busy_a",  32'(busy_a),  32'd1);

        // ---- table-driven images ----
        for (int i = 0; i < NV; i++) begin
            sel = vecs[i].sel;
            pulse_start();
            check("ready_low_after_start", 32'(rdy), 32'd0);
            for (int k = 0; k < 4; k++) begin
                send_byte(vecs[i].n[8*k +: 8], vecs[i].rnd ? int'($urandom_range(0, 5)) : 0);
            end
            for (int w = 0; w < int'(vecs[i].nsend); w++) begin
                expect_write(base_of(sel) + 32'(4 * w), vecs[i].w[w]);
                send_word(vecs[i].w[w], vecs[i].rnd);
            end
            if (vecs[i].exp_done) begin
                check("done_lags_entry", 32'(done_s), 32'd0);
                @(negedge clk);
                check("done_rises", 32'(done_s), 32'd1);
            end
            repeat (2) @(negedge clk);
            exp_busy = !vecs[i].exp_done && !vecs[i].exp_err;
            check("v_done",     32'(done_s),     32'(vecs[i].exp_done));
            check("v_err",      32'(err_s),      32'(vecs[i].exp_err));
            check("v_core_rst", 32'(core_rst_s), 32'(!vecs[i].exp_done));
            check("v_busy",     32'(busy_s),     32'(exp_busy));
            check("v_ready",    32'(rdy),        32'(exp_busy));
            check("v_pending",  32'(pending()),  32'd0);
        end

        // ---- ERR: excess bytes refused, then restart ----
        sel = 1;
        pulse_start();
        send_byte(8'h11, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
        valid_r = 1'b1;
        byte_r  = 8'h55;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("err_ready_low", 32'(rdy), 32'd0);
        end
        valid_r = 1'b0;
        check("err_set",      32'(err_s),      32'd1);
        check("err_core_rst", 32'(core_rst_s), 32'd1);
        pulse_start();
        check("err_cleared",     32'(err_s),      32'd0);
        check("err_restart_rst", 32'(core_rst_s), 32'd1);
        send_byte(8'h01, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
        expect_write(32'h0000_0100, 32'h1122_3344);
        send_word(32'h1122_3344, 0);
        repeat (2) @(negedge clk);
        check("err_reload_done", 32'(done_s), 32'd1);

        // ---- start after 2 of 4 bytes of word 1 ----
        sel = 0;
        w0  = 32'h0C0F_FEE0;
        w1  = 32'h7777_8888;
        pulse_start();
        send_byte(8'h02, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
        expect_write(32'h0, w0);
        send_word(w0, 0);
        send_byte(w1[7:0], 0);
        send_byte(w1[15:8], 0);
        pulse_start();
        check("mid_restart_done", 32'(done_s), 32'd0);
        send_byte(8'h01, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
        expect_write(32'h0, 32'hCAFE_F00D);
        send_word(32'hCAFE_F00D, 0);
        repeat (2) @(negedge clk);
        check("mid_restart_reload_done", 32'(done_s),    32'd1);
        check("mid_restart_pending",     32'(pending()), 32'd0);

        // ---- start coincident with the 4th byte of a word ----
        pulse_start();
        send_byte(8'h01, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
        send_byte(8'hAA, 0); send_byte(8'hBB, 0); send_byte(8'hCC, 0);
        valid_r = 1'b1;
        byte_r  = 8'hDD;
        start_r = 1'b1;
        @(negedge clk);
        start_r = 1'b0;
        valid_r = 1'b0;
        check("coinc_ready_low", 32'(rdy),  32'd0);
        check("coinc_no_write",  32'(we_s), 32'd0);
        @(negedge clk);
        check("coinc_ready_back", 32'(rdy),    32'd1);
        check("coinc_busy",       32'(busy_s), 32'd1);
        send_byte(8'h01, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
        expect_write(32'h0, 32'h0BAD_CAFE);
        send_word(32'h0BAD_CAFE, 0);
        repeat (2) @(negedge clk);
        check("coinc_reload_done", 32'(done_s), 32'd1);

        // ---- rst during the we_o cycle ----
        pulse_start();
        send_byte(8'h02, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
        expect_write(32'h0, 32'h1357_9BDF);
        send_word(32'h1357_9BDF, 0);
        check("rstw_we_high", 32'(we_a), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("rstw_we",       32'(we_a),       32'd0);
        check("rstw_busy",     32'(busy_a),     32'd0);
        check("rstw_done",     32'(done_a),     32'd0);
        check("rstw_core_rst", 32'(core_rst_a), 32'd1);
        check("rstw_ready",    32'(ready_a),    32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rstw_ready_back", 32'(ready_a), 32'd1);
        send_byte(8'h01, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
        expect_write(32'h0, 32'h2468_ACE0);
        send_word(32'h2468_ACE0, 0);
        repeat (2) @(negedge clk);
        check("rstw_reload_done",     32'(done_a),     32'd1);
        check("rstw_reload_core_rst", 32'(core_rst_a), 32'd0);
        check("rstw_pending",         32'(pending()),  32'd0);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
